// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 32-bit ALU: it accepts R-type ops over valid/ready and
// returns the result with an exception code over a valid/ready response port.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_overfl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic [1:0]       out_exc,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] cnt_ops,
    output logic [CNT_W-1:0] cnt_ovf
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [1:0] ExcNone    = 2'b00;
    localparam logic [1:0] ExcOverfl  = 2'b01;
    localparam logic [1:0] ExcIllegal = 2'b10;

    state_e r_state;
    state_e w_state_next;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_ctr;
    logic [TAG_W-1:0] r_tag;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_zero;
    logic [1:0]       r_out_exc;
    logic [TAG_W-1:0] r_out_tag;
    logic [CNT_W-1:0] r_cnt_ops;
    logic [CNT_W-1:0] r_cnt_ovf;

    logic [3:0] w_ctr;
    logic       w_legal;
    logic       w_accept;
    logic       w_out_hs;
    logic       w_signed_op;

    always_comb begin
        w_ctr   = 4'b0000;
        w_legal = 1'b1;
        case (in_funct)
            6'h20:   w_ctr = 4'b0000;
            6'h21:   w_ctr = 4'b0001;
            6'h22:   w_ctr = 4'b0010;
            6'h23:   w_ctr = 4'b0011;
            6'h24:   w_ctr = 4'b0100;
            6'h25:   w_ctr = 4'b0101;
            6'h26:   w_ctr = 4'b0110;
            6'h27:   w_ctr = 4'b0111;
            6'h2A:   w_ctr = 4'b1010;
            6'h2B:   w_ctr = 4'b1011;
            default: w_legal = 1'b0;
        endcase
    end

    // A pending response blocks new requests unless it is being consumed this cycle.
    assign in_ready = rst_n & ((r_state == StIdle) | ((r_state == StResp) & out_ready));
    assign w_accept = in_valid & in_ready;
    assign w_out_hs = (r_state == StResp) & out_ready;
    // Only signed add/sub can raise an overflow exception.
    assign w_signed_op = (r_alu_ctr == 4'b0000) | (r_alu_ctr == 4'b0010);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_legal ? StExec : StResp;
                end
            end
            StExec: begin
                w_state_next = StResp;
            end
            StResp: begin
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_next = w_legal ? StExec : StResp;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctr   <= 4'b0000;
            r_tag       <= '0;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_zero  <= 1'b0;
            r_out_exc   <= ExcNone;
            r_out_tag   <= '0;
            r_cnt_ops   <= '0;
            r_cnt_ovf   <= '0;
        end else begin
            if (w_accept && w_legal) begin
                r_alu_a   <= in_a;
                r_alu_b   <= in_b;
                r_alu_ctr <= w_ctr;
                r_tag     <= in_tag;
            end

            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_cnt_ops   <= r_cnt_ops + CNT_W'(1);
                if (r_out_exc == ExcOverfl && r_cnt_ovf != {CNT_W{1'b1}}) begin
                    r_cnt_ovf <= r_cnt_ovf + CNT_W'(1);
                end
            end

            // Later assignments win, so a back-to-back illegal op re-raises out_valid.
            if (r_state == StExec) begin
                r_out_valid <= 1'b1;
                r_out_res   <= alu_res;
                r_out_zero  <= alu_zero;
                r_out_exc   <= (alu_overfl && w_signed_op) ? ExcOverfl : ExcNone;
                r_out_tag   <= r_tag;
            end else if (w_accept && !w_legal) begin
                r_out_valid <= 1'b1;
                r_out_res   <= '0;
                r_out_zero  <= 1'b0;
                r_out_exc   <= ExcIllegal;
                r_out_tag   <= in_tag;
            end
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_ctr   = r_alu_ctr;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_zero  = r_out_zero;
    assign out_exc   = r_out_exc;
    assign out_tag   = r_out_tag;
    assign cnt_ops   = r_cnt_ops;
    assign cnt_ovf   = r_cnt_ovf;

endmodule
